// File: rtl/operand_xbar_pkg.sv
// Shared opcode constants, decode classes and sub-action field layout for the
// PHV operand crossbar.
package operand_xbar_pkg;

    localparam logic [7:0] OPC_01 = 8'h01;
    localparam logic [7:0] OPC_02 = 8'h02;
    localparam logic [7:0] OPC_03 = 8'h03;
    localparam logic [7:0] OPC_04 = 8'h04;
    localparam logic [7:0] OPC_05 = 8'h05;
    localparam logic [7:0] OPC_06 = 8'h06;
    localparam logic [7:0] OPC_07 = 8'h07;
    localparam logic [7:0] OPC_08 = 8'h08;
    localparam logic [7:0] OPC_09 = 8'h09;
    localparam logic [7:0] OPC_0A = 8'h0A;
    localparam logic [7:0] OPC_0B = 8'h0B;
    localparam logic [7:0] OPC_0C = 8'h0C;
    localparam logic [7:0] OPC_0E = 8'h0E;
    localparam logic [7:0] OPC_10 = 8'h10;
    localparam logic [7:0] OPC_11 = 8'h11;
    localparam logic [7:0] OPC_12 = 8'h12;
    localparam logic [7:0] OPC_13 = 8'h13;
    localparam logic [7:0] OPC_14 = 8'h14;
    localparam logic [7:0] OPC_17 = 8'h17;
    localparam logic [7:0] OPC_18 = 8'h18;
    localparam logic [7:0] OPC_1B = 8'h1B;
    localparam logic [7:0] OPC_1C = 8'h1C;
    localparam logic [7:0] OPC_1D = 8'h1D;

    // Field positions: the opcode and index fields are measured down from the
    // top of the sub-action, imm and st up from bit 0.
    localparam int OP_W       = 8;
    localparam int IDX_W      = 6;
    localparam int OP_TOP_OFS = 1;
    localparam int IA_TOP_OFS = 9;
    localparam int IB_TOP_OFS = 15;
    localparam int IC_TOP_OFS = 21;
    localparam int IMM_LSB    = 0;
    localparam int ST_LSB     = 6;

    typedef enum logic [2:0] {
        CLS_BYPASS,
        CLS_RR,
        CLS_RI,
        CLS_SET,
        CLS_UNARY,
        CLS_SEL3,
        CLS_SELI,
        CLS_STATEFUL
    } op_class_e;

    function automatic op_class_e decode_class(input logic [7:0] op);
        case (op)
            OPC_01, OPC_02, OPC_04, OPC_06, OPC_08, OPC_0B,
            OPC_12, OPC_13, OPC_17, OPC_18, OPC_1C:          decode_class = CLS_RR;
            OPC_03, OPC_05, OPC_07, OPC_09, OPC_0A,
            OPC_1B, OPC_1D:                                  decode_class = CLS_RI;
            OPC_0E:                                          decode_class = CLS_SET;
            OPC_14:                                          decode_class = CLS_UNARY;
            OPC_10:                                          decode_class = CLS_SEL3;
            OPC_11:                                          decode_class = CLS_SELI;
            OPC_0C:                                          decode_class = CLS_STATEFUL;
            default:                                         decode_class = CLS_BYPASS;
        endcase
    endfunction

endpackage

// File: rtl/operand_xbar_operand_sel.sv
// Combinational operand decode for one PHV container: picks A/B/C/D from the
// container file, the immediate or the stateful word according to the opcode.
module operand_sel
    import operand_xbar_pkg::*;
#(
    parameter int N_CONT = 64,
    parameter int CONT_W = 32,
    parameter int ACT_W  = 64
) (
    input  logic [N_CONT*CONT_W-1:0] conts,
    input  logic [CONT_W-1:0]        self_cont,
    input  logic [ACT_W-1:0]         sub_act,
    output logic [CONT_W-1:0]        opnd_a,
    output logic [CONT_W-1:0]        opnd_b,
    output logic [CONT_W-1:0]        opnd_c,
    output logic [CONT_W-1:0]        opnd_d,
    output logic                     idx_err
);

    localparam logic [IDX_W:0] N_IDX = (IDX_W+1)'(N_CONT);

    logic [OP_W-1:0]   op;
    logic [IDX_W-1:0]  ia, ib, ic;
    logic [CONT_W-1:0] imm, st;
    logic [CONT_W-1:0] ca, cb, cc;
    logic              oor_a, oor_b, oor_c;
    op_class_e         cls;
    logic              unused_sub_act;

    // Out-of-range indices match no container and therefore read as zero.
    function automatic logic [CONT_W-1:0] pick(input logic [N_CONT*CONT_W-1:0] v,
                                               input logic [IDX_W-1:0] idx);
        pick = '0;
        for (int i = 0; i < N_CONT; i++) begin
            if ({1'b0, idx} == (IDX_W+1)'(i)) pick = v[i*CONT_W +: CONT_W];
        end
    endfunction

    assign unused_sub_act = ^sub_act;

    always_comb begin
        op    = sub_act[ACT_W-OP_TOP_OFS -: OP_W];
        ia    = sub_act[ACT_W-IA_TOP_OFS -: IDX_W];
        ib    = sub_act[ACT_W-IB_TOP_OFS -: IDX_W];
        ic    = sub_act[ACT_W-IC_TOP_OFS -: IDX_W];
        imm   = sub_act[IMM_LSB +: CONT_W];
        st    = sub_act[ST_LSB +: CONT_W];
        cls   = decode_class(op);
        ca    = pick(conts, ia);
        cb    = pick(conts, ib);
        cc    = pick(conts, ic);
        oor_a = ({1'b0, ia} >= N_IDX);
        oor_b = ({1'b0, ib} >= N_IDX);
        oor_c = ({1'b0, ic} >= N_IDX);

        opnd_a  = self_cont;
        opnd_b  = '0;
        opnd_c  = self_cont;
        opnd_d  = self_cont;
        idx_err = 1'b0;

        case (cls)
            CLS_RR: begin
                opnd_a  = ca;
                opnd_b  = cb;
                idx_err = oor_a | oor_b;
            end
            CLS_RI: begin
                opnd_a  = ca;
                opnd_b  = imm;
                idx_err = oor_a;
            end
            CLS_SET: begin
                opnd_a = '0;
                opnd_b = imm;
            end
            CLS_UNARY: begin
                opnd_a  = ca;
                idx_err = oor_a;
            end
            CLS_SEL3: begin
                opnd_a  = ca;
                opnd_b  = cb;
                opnd_c  = cc;
                idx_err = oor_a | oor_b | oor_c;
            end
            CLS_SELI: begin
                opnd_a  = ca;
                opnd_b  = cb;
                opnd_c  = imm;
                idx_err = oor_a | oor_b;
            end
            CLS_STATEFUL: begin
                opnd_a  = ca;
                opnd_b  = cb;
                opnd_c  = cc;
                opnd_d  = st;
                idx_err = oor_a | oor_b | oor_c;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/operand_xbar.sv
// PHV operand crossbar: per-container operand decode feeding a registered
// output stage backed by a one-entry skid buffer.
module operand_xbar
    import operand_xbar_pkg::*;
#(
    parameter int N_CONT = 64,
    parameter int CONT_W = 32,
    parameter int ACT_W  = 64,
    parameter int META_W = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_CONT*CONT_W+META_W-1:0] phv_in,
    input  logic [(N_CONT+1)*ACT_W-1:0]  action_in,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [N_CONT*CONT_W-1:0]     opnd_a,
    output logic [N_CONT*CONT_W-1:0]     opnd_b,
    output logic [N_CONT*CONT_W-1:0]     opnd_c,
    output logic [N_CONT*CONT_W-1:0]     opnd_d,
    output logic [META_W-1:0]            meta_out,
    output logic [(N_CONT+1)*ACT_W-1:0]  action_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         idx_err
);

    localparam int OPND_W = N_CONT*CONT_W;
    localparam int ACTV_W = (N_CONT+1)*ACT_W;
    localparam int BUN_W  = 4*OPND_W + META_W + ACTV_W;

    logic [OPND_W-1:0] conts;
    logic [OPND_W-1:0] new_a, new_b, new_c, new_d;
    logic [N_CONT-1:0] sel_err;
    logic [BUN_W-1:0]  new_bundle;

    logic [BUN_W-1:0]  out_bundle_d, out_bundle_q;
    logic [BUN_W-1:0]  skid_bundle_d, skid_bundle_q;
    logic              out_valid_d, out_valid_q;
    logic              skid_valid_d, skid_valid_q;
    logic              in_ready_d, in_ready_q;
    logic              idx_err_d, idx_err_q;
    logic              accept, pop;

    assign conts = phv_in[META_W +: OPND_W];

    for (genvar k = 0; k < N_CONT; k++) begin : g_sel
        operand_sel #(
            .N_CONT (N_CONT),
            .CONT_W (CONT_W),
            .ACT_W  (ACT_W)
        ) u_sel (
            .conts     (conts),
            .self_cont (conts[k*CONT_W +: CONT_W]),
            .sub_act   (action_in[(k+1)*ACT_W +: ACT_W]),
            .opnd_a    (new_a[k*CONT_W +: CONT_W]),
            .opnd_b    (new_b[k*CONT_W +: CONT_W]),
            .opnd_c    (new_c[k*CONT_W +: CONT_W]),
            .opnd_d    (new_d[k*CONT_W +: CONT_W]),
            .idx_err   (sel_err[k])
        );
    end

    assign new_bundle = {new_a, new_b, new_c, new_d, phv_in[META_W-1:0], action_in};

    // The skid only fills while the output is stalled, and in_ready is low
    // whenever it is full, so an accept never coincides with a full skid.
    always_comb begin
        accept        = in_valid & in_ready_q;
        pop           = out_valid_q & out_ready;
        out_bundle_d  = out_bundle_q;
        skid_bundle_d = skid_bundle_q;
        out_valid_d   = out_valid_q;
        skid_valid_d  = skid_valid_q;

        if (!out_valid_q || pop) begin
            if (skid_valid_q) begin
                out_bundle_d = skid_bundle_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_bundle_d = new_bundle;
                out_valid_d  = 1'b1;
            end else begin
                out_valid_d  = 1'b0;
            end
        end else if (accept) begin
            skid_bundle_d = new_bundle;
            skid_valid_d  = 1'b1;
        end

        in_ready_d = ~skid_valid_d;
        idx_err_d  = idx_err_q | (accept & (|sel_err));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_bundle_q  <= '0;
            skid_bundle_q <= '0;
            out_valid_q   <= 1'b0;
            skid_valid_q  <= 1'b0;
            in_ready_q    <= 1'b1;
            idx_err_q     <= 1'b0;
        end else begin
            out_bundle_q  <= out_bundle_d;
            skid_bundle_q <= skid_bundle_d;
            out_valid_q   <= out_valid_d;
            skid_valid_q  <= skid_valid_d;
            in_ready_q    <= in_ready_d;
            idx_err_q     <= idx_err_d;
        end
    end

    assign {opnd_a, opnd_b, opnd_c, opnd_d, meta_out, action_out} = out_bundle_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign idx_err   = idx_err_q;

endmodule

// File: tb/tb_operand_xbar.sv
// Randomized bench for operand_xbar with a queue-based reference model and a
// per-cycle output compare, plus directed literal checks.
module tb_operand_xbar;

    localparam int NC     = 48;
    localparam int CW     = 32;
    localparam int AW     = 64;
    localparam int MW     = 256;
    localparam int OW     = NC*CW;
    localparam int PHV_W  = OW + MW;
    localparam int ACTV_W = (NC+1)*AW;

    typedef struct packed {
        logic [OW-1:0]     a;
        logic [OW-1:0]     b;
        logic [OW-1:0]     c;
        logic [OW-1:0]     d;
        logic [MW-1:0]     meta;
        logic [ACTV_W-1:0] act;
        logic              err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [PHV_W-1:0]  phv_in;
    logic [ACTV_W-1:0] action_in;
    logic              in_valid;
    logic              in_ready;
    logic [OW-1:0]     opnd_a, opnd_b, opnd_c, opnd_d;
    logic [MW-1:0]     meta_out;
    logic [ACTV_W-1:0] action_out;
    logic              out_valid;
    logic              out_ready;
    logic              idx_err;

    int   vectors    = 0;
    int   miscompares = 0;
    int   out_xfers  = 0;
    exp_t q[$];
    logic merr;

    logic [7:0] ops [26] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                             8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0E, 8'h10, 8'h11, 8'h12,
                             8'h13, 8'h14, 8'h17, 8'h18, 8'h1B, 8'h1C, 8'h1D, 8'h00,
                             8'h0F, 8'hFF};

    operand_xbar #(
        .N_CONT (NC),
        .CONT_W (CW),
        .ACT_W  (AW),
        .META_W (MW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .phv_in     (phv_in),
        .action_in  (action_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opnd_a     (opnd_a),
        .opnd_b     (opnd_b),
        .opnd_c     (opnd_c),
        .opnd_d     (opnd_d),
        .meta_out   (meta_out),
        .action_out (action_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .idx_err    (idx_err)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d]: got %0h expected %0h at %0t", nm, idx, act, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] cont(input logic [PHV_W-1:0] p, input int idx);
        return (idx < NC) ? p[MW + idx*CW +: CW] : '0;
    endfunction

    // Reference: the operands each container must see, straight from the opcode tables.
    function automatic exp_t model(input logic [PHV_W-1:0] p, input logic [ACTV_W-1:0] ac);
        exp_t e;
        logic [AW-1:0] s;
        logic [7:0] op;
        int ia, ib, ic;
        logic [CW-1:0] sc, imm, st, va, vb, vc, vd;
        e.meta = p[MW-1:0];
        e.act  = ac;
        e.err  = 1'b0;
        e.a = '0; e.b = '0; e.c = '0; e.d = '0;
        for (int k = 0; k < NC; k++) begin
            s   = ac[(k+1)*AW +: AW];
            op  = s[63:56];
            ia  = int'(s[55:50]);
            ib  = int'(s[49:44]);
            ic  = int'(s[43:38]);
            imm = s[31:0];
            st  = s[37:6];
            sc  = cont(p, k);
            va = sc; vb = '0; vc = sc; vd = sc;
            if (op inside {8'h01, 8'h02, 8'h04, 8'h06, 8'h08, 8'h0B, 8'h12, 8'h13, 8'h17, 8'h18, 8'h1C}) begin
                va = cont(p, ia); vb = cont(p, ib);
                e.err = e.err | (ia >= NC) | (ib >= NC);
            end else if (op inside {8'h03, 8'h05, 8'h07, 8'h09, 8'h0A, 8'h1B, 8'h1D}) begin
                va = cont(p, ia); vb = imm;
                e.err = e.err | (ia >= NC);
            end else if (op == 8'h0E) begin
                va = '0; vb = imm;
            end else if (op == 8'h14) begin
                va = cont(p, ia);
                e.err = e.err | (ia >= NC);
            end else if (op == 8'h10) begin
                va = cont(p, ia); vb = cont(p, ib); vc = cont(p, ic);
                e.err = e.err | (ia >= NC) | (ib >= NC) | (ic >= NC);
            end else if (op == 8'h11) begin
                va = cont(p, ia); vb = cont(p, ib); vc = imm;
                e.err = e.err | (ia >= NC) | (ib >= NC);
            end else if (op == 8'h0C) begin
                va = cont(p, ia); vb = cont(p, ib); vc = cont(p, ic); vd = st;
                e.err = e.err | (ia >= NC) | (ib >= NC) | (ic >= NC);
            end
            e.a[k*CW +: CW] = va;
            e.b[k*CW +: CW] = vb;
            e.c[k*CW +: CW] = vc;
            e.d[k*CW +: CW] = vd;
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            merr = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() != 0) void'(q.pop_front());
                out_xfers++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(phv_in, action_in));
                merr = merr | q[q.size()-1].err;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", 0, 64'(out_valid), 64'd0);
            chk("rst_in_ready", 0, 64'(in_ready), 64'd1);
            chk("rst_idx_err", 0, 64'(idx_err), 64'd0);
            chk("rst_outputs_zero", 0,
                64'(|{opnd_a, opnd_b, opnd_c, opnd_d, meta_out, action_out}), 64'd0);
        end else begin
            chk("out_valid", 0, 64'(out_valid), 64'(q.size() != 0));
            chk("in_ready", 0, 64'(in_ready), 64'(q.size() < 2));
            chk("idx_err", 0, 64'(idx_err), 64'(merr));
            if (out_valid && q.size() != 0) begin
                for (int k = 0; k < NC; k++) begin
                    chk("opnd_a", k, 64'(opnd_a[k*CW +: CW]), 64'(q[0].a[k*CW +: CW]));
                    chk("opnd_b", k, 64'(opnd_b[k*CW +: CW]), 64'(q[0].b[k*CW +: CW]));
                    chk("opnd_c", k, 64'(opnd_c[k*CW +: CW]), 64'(q[0].c[k*CW +: CW]));
                    chk("opnd_d", k, 64'(opnd_d[k*CW +: CW]), 64'(q[0].d[k*CW +: CW]));
                end
                for (int j = 0; j < MW/64; j++)
                    chk("meta_out", j, meta_out[j*64 +: 64], q[0].meta[j*64 +: 64]);
                for (int j = 0; j < NC+1; j++)
                    chk("action_out", j, action_out[j*AW +: AW], q[0].act[j*AW +: AW]);
            end
        end
    end

    function automatic logic [PHV_W-1:0] rand_phv();
        logic [PHV_W-1:0] r;
        for (int i = 0; i < PHV_W/32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [5:0] rand_idx(input bit oor);
        if (oor && $urandom_range(0, 15) == 0) return 6'($urandom_range(0, 63));
        return 6'($urandom_range(0, NC-1));
    endfunction

    function automatic logic [ACTV_W-1:0] rand_act(input bit oor);
        logic [ACTV_W-1:0] r;
        logic [AW-1:0] s;
        for (int i = 0; i < ACTV_W/32; i++) r[i*32 +: 32] = $urandom();
        for (int k = 0; k < NC; k++) begin
            s = r[(k+1)*AW +: AW];
            s[63:56] = ops[$urandom_range(0, 25)];
            s[55:50] = rand_idx(oor);
            s[49:44] = rand_idx(oor);
            s[43:38] = rand_idx(oor);
            r[(k+1)*AW +: AW] = s;
        end
        return r;
    endfunction

    function automatic logic [AW-1:0] mk(input logic [7:0] op, input logic [5:0] ia,
                                         input logic [5:0] ib, input logic [5:0] ic,
                                         input logic [37:0] lo);
        return {op, ia, ib, ic, lo};
    endfunction

    task automatic send(input logic [PHV_W-1:0] p, input logic [ACTV_W-1:0] a,
                        input logic v, input logic r);
        #1;
        phv_in    = p;
        action_in = a;
        in_valid  = v;
        out_ready = r;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(phv_in, action_in, 1'b0, 1'b1);
    endtask

    initial begin
        logic [PHV_W-1:0]  p, p1, p2, p3;
        logic [ACTV_W-1:0] a;
        int start;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        phv_in = '0; action_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_opnd_a5", 5, 64'(opnd_a[5*CW +: CW]), 64'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Register-register pick, stateful D and bypass, with literal results.
        p = rand_phv();
        p[MW + 0*CW +: CW] = 32'h0000_1000;
        p[MW + 1*CW +: CW] = 32'h0000_0077;
        p[MW + 2*CW +: CW] = 32'h0000_0010;
        p[MW + 3*CW +: CW] = 32'h0000_0020;
        p[MW + 5*CW +: CW] = 32'h0000_0055;
        a = '0;
        a[1*AW +: AW] = mk(8'h0C, 6'd1, 6'd2, 6'd3, {32'hABCD_1234, 6'd0});
        a[2*AW +: AW] = mk(8'h00, 6'd9, 6'd9, 6'd9, 38'd0);
        a[6*AW +: AW] = mk(8'h01, 6'd2, 6'd3, 6'd0, 38'd0);
        send(p, a, 1'b1, 1'b1);
        chk("lit_out_valid_1cyc", 0, 64'(out_valid), 64'd1);
        chk("lit_c5_a", 5, 64'(opnd_a[5*CW +: CW]), 64'h10);
        chk("lit_c5_b", 5, 64'(opnd_b[5*CW +: CW]), 64'h20);
        chk("lit_c5_c", 5, 64'(opnd_c[5*CW +: CW]), 64'h55);
        chk("lit_c5_d", 5, 64'(opnd_d[5*CW +: CW]), 64'h55);
        chk("lit_c0_d_st", 0, 64'(opnd_d[0*CW +: CW]), 64'hABCD_1234);
        chk("lit_c0_a", 0, 64'(opnd_a[0*CW +: CW]), 64'h77);
        chk("lit_c0_c", 0, 64'(opnd_c[0*CW +: CW]), 64'h20);
        chk("lit_c1_a_bypass", 1, 64'(opnd_a[1*CW +: CW]), 64'h77);
        chk("lit_c1_b_bypass", 1, 64'(opnd_b[1*CW +: CW]), 64'h0);
        idle(1);

        // Three bundles against a three-cycle stall, then release.
        p1 = rand_phv(); p1[31:0] = 32'd1;
        p2 = rand_phv(); p2[31:0] = 32'd2;
        p3 = rand_phv(); p3[31:0] = 32'd3;
        send(p1, rand_act(1'b0), 1'b1, 1'b0);
        chk("bp_meta_first", 0, 64'(meta_out[31:0]), 64'd1);
        send(p2, rand_act(1'b0), 1'b1, 1'b0);
        chk("bp_in_ready_skid_full", 0, 64'(in_ready), 64'd0);
        a = rand_act(1'b0);
        send(p3, a, 1'b1, 1'b0);
        chk("bp_in_ready_hold", 0, 64'(in_ready), 64'd0);
        chk("bp_meta_held", 0, 64'(meta_out[31:0]), 64'd1);
        send(p3, a, 1'b1, 1'b1);
        chk("bp_meta_second", 0, 64'(meta_out[31:0]), 64'd2);
        chk("bp_in_ready_rises", 0, 64'(in_ready), 64'd1);
        send(p3, a, 1'b1, 1'b1);
        chk("bp_meta_third", 0, 64'(meta_out[31:0]), 64'd3);
        idle(2);

        // Full-rate streaming.
        start = out_xfers;
        for (int i = 0; i < 100; i++) begin
            send(rand_phv(), rand_act(1'b0), 1'b1, 1'b1);
            chk("burst_in_ready", i, 64'(in_ready), 64'd1);
        end
        idle(1);
        chk("burst_out_count", 0, 64'(out_xfers - start), 64'd100);

        for (int i = 0; i < 1500; i++)
            send(rand_phv(), rand_act(1'b0), 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 6));
        idle(3);

        // Reset with the skid full.
        send(rand_phv(), rand_act(1'b0), 1'b1, 1'b0);
        send(rand_phv(), rand_act(1'b0), 1'b1, 1'b0);
        chk("rst_pre_skid_full", 0, 64'(in_ready), 64'd0);
        #1 rst_n = 1'b0; in_valid = 1'b0;
        #2;
        chk("rst_low_out_valid", 0, 64'(out_valid), 64'd0);
        chk("rst_low_in_ready", 0, 64'(in_ready), 64'd1);
        @(negedge clk);
        p = rand_phv(); p[31:0] = 32'h0000_BEEF;
        #1 rst_n = 1'b1;
        phv_in = p; action_in = rand_act(1'b0); in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("rst_first_accept", 0, 64'(out_valid), 64'd1);
        chk("rst_no_stale_meta", 0, 64'(meta_out[31:0]), 64'h0000_BEEF);
        idle(2);

        // Out-of-range index on container 7 with N_CONT=48.
        p = rand_phv();
        a = '0;
        a[8*AW +: AW] = mk(8'h01, 6'd50, 6'd4, 6'd0, 38'd0);
        send(p, a, 1'b1, 1'b1);
        chk("oor_opnd_a", 7, 64'(opnd_a[7*CW +: CW]), 64'd0);
        chk("oor_opnd_b", 7, 64'(opnd_b[7*CW +: CW]), 64'(p[MW + 4*CW +: CW]));
        chk("oor_idx_err", 0, 64'(idx_err), 64'd1);
        for (int i = 0; i < 10; i++) send(rand_phv(), rand_act(1'b0), 1'b1, 1'b1);
        idle(1);
        chk("oor_idx_err_sticky", 0, 64'(idx_err), 64'd1);

        for (int i = 0; i < 500; i++)
            send(rand_phv(), rand_act(1'b1), 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 5));
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/operand_xbar.md
OPERAND_XBAR -- requirements
Module: operand_xbar

Interface
REQ-001 Parameter N_CONT, default 64: number of PHV containers; legal range 2..64.
REQ-002 Parameter CONT_W, default 32: container width in bits; legal range 8..32.
REQ-003 Parameter ACT_W, default 64: per-container sub-action width.
REQ-004 Parameter META_W, default 256: width of the pass-through metadata tail.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 phv_in  in  N_CONT*CONT_W+META_W  PHV; container k = phv_in[META_W+(k+1)*CONT_W-1 -: CONT_W]; metadata = phv_in[META_W-1:0].
REQ-008 action_in  in  (N_CONT+1)*ACT_W  action word; sub-action for container k = action_in[(k+1)*ACT_W +: ACT_W]; slot 0 is reserved and ignored.
REQ-009 in_valid  in  1  phv_in and action_in valid together.
REQ-010 in_ready  out  1  block can accept this cycle.
REQ-011 opnd_a, opnd_b, opnd_c, opnd_d  out  N_CONT*CONT_W each  per-container ALU operands, container k at [(k+1)*CONT_W-1 -: CONT_W].
REQ-012 meta_out  out  META_W  registered copy of the metadata tail.
REQ-013 action_out  out  (N_CONT+1)*ACT_W  action word aligned with the operands.
REQ-014 out_valid  out  1  operand bundle valid.
REQ-015 out_ready  in  1  downstream accepts the bundle.
REQ-016 idx_err  out  1  sticky flag: a decoded index was >= N_CONT.

Function
REQ-017 Handshake: a transfer occurs on an edge where in_valid=1 and in_ready=1; a transfer on the output occurs where out_valid=1 and out_ready=1.
REQ-018 Latency is exactly 1 cycle from input transfer to out_valid when the output register is empty or draining.
REQ-019 Buffering: output register plus one skid register; in_ready is registered and is 0 only when the skid register is full.
REQ-020 Backpressure: no bundle is lost, duplicated or reordered; outputs are held stable while out_valid=1 and out_ready=0.
REQ-021 Skid drain: on out_ready=1 with the skid full, the skid moves to the output and in_ready rises on the next edge.
REQ-022 A simultaneous input transfer and output transfer with an empty skid loads the output register directly.
REQ-023 Sub-action fields: op = [ACT_W-1 -: 8], ia = [ACT_W-9 -: 6], ib = [ACT_W-15 -: 6], ic = [ACT_W-21 -: 6], imm = [31:0] truncated to CONT_W, st = [37:6] truncated to CONT_W.
REQ-024 Decode classes, per container k (opcodes hex):
 - RR {01,02,04,06,08,0B,12,13,17,18,1C}: A=C[ia], B=C[ib].
 - RI {03,05,07,09,0A,1B,1D}: A=C[ia], B=imm.
 - SET {0E}: A=0, B=imm.
 - UNARY {14}: A=C[ia], B=0.
 - SEL3 {10}: A=C[ia], B=C[ib], C=C[ic].
 - SELI {11}: A=C[ia], B=C[ib], C=imm.
 - STATEFUL {0C}: A=C[ia], B=C[ib], C=C[ic], D=st.
 - default (bypass): A=C[k], B=0.
REQ-025 Operand C defaults to C[k] and D defaults to C[k] for every class that does not assign them.
REQ-026 Out-of-range index (>= N_CONT): that operand = 0 and idx_err is set on the accepting edge; idx_err is cleared only by reset.
REQ-027 Every output bit is fully defined each accepted bundle; no value is retained from an earlier bundle.
REQ-028 action_out and meta_out are captured in the same register stage as the operands.

Reset
REQ-029 While rst_n=0: out_valid=0, all operand/meta/action outputs=0, skid empty, idx_err=0, in_ready=1.
REQ-030 Reset mid-transfer discards both buffered bundles; the first post-reset transfer is accepted on the first edge with rst_n=1.

Structure
REQ-031 The shared package holds the opcode constants, decode-class enumeration and field offset constants.
REQ-032 One sub-module, operand_sel: combinational decode for a single container, instantiated N_CONT times by generate.

Verification
REQ-033 Container 5 op=01, ia=2, ib=3, C2=0x10, C3=0x20 -> one cycle later opnd_a[5]=0x10, opnd_b[5]=0x20, opnd_c[5]=opnd_d[5]=C5.
REQ-034 Container 0 op=0C, st=0xABCD1234 -> opnd_d[0]=0xABCD1234; container 1 op=00 -> opnd_a[1]=C1, opnd_b[1]=0.
REQ-035 out_ready=0 for 3 cycles with 3 bundles offered -> first held stable, second in skid, in_ready=0, third accepted only after out_ready=1; output order 1,2,3.
REQ-036 N_CONT=48, ia=50 -> opnd_a=0, idx_err=1 and still 1 after 10 further bundles.
REQ-037 Continuous in_valid=1, out_ready=1 for 100 cycles -> 100 bundles out, one per cycle, in_ready never 0.
REQ-038 rst_n pulsed low with skid full -> out_valid=0 and in_ready=1 while low; no stale bundle afterward.
